// File: rtl/sys_axilite_slave_ctrl_pkg.sv
// Shared constants for the sys_* AXI4-Lite slave blocks: FSM encoding,
// response codes and latency-counter sizing.
package sys_axilite_slave_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_RESP  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_RD_RESP  = 3'd5
  } axil_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Wide enough for read latencies 1..15.
  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/sys_axilite_slave_ctrl.sv
// AXI4-Lite slave front end: serialises host reads/writes into single-cycle
// backend strobes and returns B/R responses, one transaction in flight.
module sys_axilite_slave_ctrl
  import sys_axilite_slave_ctrl_pkg::*;
#(
  parameter int C_AWIDTH     = 32,
  parameter int C_DWIDTH     = 32,
  parameter int C_EFF_AWIDTH = 20,
  parameter int C_RD_LATENCY = 2
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [C_AWIDTH-1:0]   iAWAddr,
  input  logic                  iAWValid,
  output logic                  oAWReady,
  input  logic [C_DWIDTH-1:0]   iWData,
  input  logic [C_DWIDTH/8-1:0] iWStrb,
  input  logic                  iWValid,
  output logic                  oWReady,
  output logic [1:0]            oBResp,
  output logic                  oBValid,
  input  logic                  iBReady,
  input  logic [C_AWIDTH-1:0]   iARAddr,
  input  logic                  iARValid,
  output logic                  oARReady,
  output logic [C_DWIDTH-1:0]   oRData,
  output logic [1:0]            oRResp,
  output logic                  oRValid,
  input  logic                  iRReady,
  output logic                  oCE,
  output logic                  oWE,
  output logic [C_DWIDTH/8-1:0] oByteEn,
  output logic [C_AWIDTH-1:0]   oAddr,
  output logic [C_DWIDTH-1:0]   oWrData,
  input  logic [C_DWIDTH-1:0]   iRdData
);

  localparam int STRB_W = C_DWIDTH / 8;
  localparam logic [C_AWIDTH-1:0]  ADDR_MASK = {C_AWIDTH{1'b1}} >> (C_AWIDTH - C_EFF_AWIDTH);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD  = LAT_CNT_W'(C_RD_LATENCY - 1);

  axil_state_e           state_q, state_d;
  logic                  wr_rdy_q, wr_rdy_d;
  logic                  ar_rdy_q, ar_rdy_d;
  logic                  b_vld_q, b_vld_d;
  logic                  r_vld_q, r_vld_d;
  logic                  ce_q, ce_d;
  logic                  we_q, we_d;
  logic [STRB_W-1:0]     be_q, be_d;
  logic [C_AWIDTH-1:0]   addr_q, addr_d;
  logic [C_DWIDTH-1:0]   wdata_q, wdata_d;
  logic [C_DWIDTH-1:0]   rdata_q, rdata_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  last_wr_q, last_wr_d;
  logic                  wr_elig, rd_elig;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= ST_IDLE;
      wr_rdy_q  <= 1'b0;
      ar_rdy_q  <= 1'b0;
      b_vld_q   <= 1'b0;
      r_vld_q   <= 1'b0;
      ce_q      <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_rdy_q  <= wr_rdy_d;
      ar_rdy_q  <= ar_rdy_d;
      b_vld_q   <= b_vld_d;
      r_vld_q   <= r_vld_d;
      ce_q      <= ce_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_rdy_d  = 1'b0;
    ar_rdy_d  = 1'b0;
    b_vld_d   = b_vld_q;
    r_vld_d   = r_vld_q;
    ce_d      = 1'b0;
    we_d      = 1'b0;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    last_wr_d = last_wr_q;
    wr_elig   = iAWValid & iWValid;
    rd_elig   = iARValid;

    unique case (state_q)
      // Readies are registered: IDLE first grants, then the handshake
      // completes in the cycle the ready is visible to the host.
      ST_IDLE: begin
        if (wr_rdy_q) begin
          if (wr_elig) begin
            state_d   = ST_WR_ISSUE;
            ce_d      = 1'b1;
            we_d      = 1'b1;
            addr_d    = iAWAddr & ADDR_MASK;
            wdata_d   = iWData;
            be_d      = iWStrb;
            last_wr_d = 1'b1;
          end
        end else if (ar_rdy_q) begin
          if (rd_elig) begin
            state_d   = ST_RD_ISSUE;
            ce_d      = 1'b1;
            addr_d    = iARAddr & ADDR_MASK;
            be_d      = '1;
            last_wr_d = 1'b0;
          end
        end else if (wr_elig && (!rd_elig || !last_wr_q)) begin
          wr_rdy_d = 1'b1;
        end else if (rd_elig) begin
          ar_rdy_d = 1'b1;
        end
      end
      ST_WR_ISSUE: begin
        b_vld_d = 1'b1;
        state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (iBReady) begin
          b_vld_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_RD_ISSUE: begin
        cnt_d   = LAT_LOAD;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = iRdData;
          r_vld_d = 1'b1;
          state_d = ST_RD_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RD_RESP: begin
        if (iRReady) begin
          r_vld_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign oAWReady = wr_rdy_q;
  assign oWReady  = wr_rdy_q;
  assign oARReady = ar_rdy_q;
  assign oBValid  = b_vld_q;
  assign oBResp   = AXI_RESP_OKAY;
  assign oRValid  = r_vld_q;
  assign oRResp   = AXI_RESP_OKAY;
  assign oRData   = rdata_q;
  assign oCE      = ce_q;
  assign oWE      = we_q;
  assign oByteEn  = be_q;
  assign oAddr    = addr_q;
  assign oWrData  = wdata_q;

endmodule

// File: tb/tb_sys_axilite_slave_ctrl.sv
// Randomised bench for sys_axilite_slave_ctrl against a memory-level model:
// a backend memory sits behind the strobe port and reads are compared to it.
module tb_sys_axilite_slave_ctrl;

  localparam int LAT = 2;
  localparam logic [31:0] EMASK = 32'h000F_FFFF;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic [31:0] iAWAddr = '0;
  logic        iAWValid = 1'b0;
  logic        oAWReady;
  logic [31:0] iWData = '0;
  logic [3:0]  iWStrb = '0;
  logic        iWValid = 1'b0;
  logic        oWReady;
  logic [1:0]  oBResp;
  logic        oBValid;
  logic        iBReady = 1'b0;
  logic [31:0] iARAddr = '0;
  logic        iARValid = 1'b0;
  logic        oARReady;
  logic [31:0] oRData;
  logic [1:0]  oRResp;
  logic        oRValid;
  logic        iRReady = 1'b0;
  logic        oCE;
  logic        oWE;
  logic [3:0]  oByteEn;
  logic [31:0] oAddr;
  logic [31:0] oWrData;
  logic [31:0] iRdData = '0;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int ce_cnt = 0;
  int rd_due = -1;
  logic [31:0] rd_addr = '0;

  logic [31:0] mmem [logic [31:0]];
  logic [31:0] bmem [logic [31:0]];

  sys_axilite_slave_ctrl #(
    .C_AWIDTH(32), .C_DWIDTH(32), .C_EFF_AWIDTH(20), .C_RD_LATENCY(LAT)
  ) dut (
    .iClk(iClk), .iRst(iRst),
    .iAWAddr(iAWAddr), .iAWValid(iAWValid), .oAWReady(oAWReady),
    .iWData(iWData), .iWStrb(iWStrb), .iWValid(iWValid), .oWReady(oWReady),
    .oBResp(oBResp), .oBValid(oBValid), .iBReady(iBReady),
    .iARAddr(iARAddr), .iARValid(iARValid), .oARReady(oARReady),
    .oRData(oRData), .oRResp(oRResp), .oRValid(oRValid), .iRReady(iRReady),
    .oCE(oCE), .oWE(oWE), .oByteEn(oByteEn), .oAddr(oAddr), .oWrData(oWrData),
    .iRdData(iRdData)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) begin
    cyc    <= cyc + 1;
    ce_cnt <= ce_cnt + (oCE ? 1 : 0);
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mm_rd(input logic [31:0] a);
    return mmem.exists(a & EMASK) ? mmem[a & EMASK] : 32'h0;
  endfunction

  // Backend: stores what the DUT strobes out, and returns read data only in
  // the exact cycle it is due; every other cycle carries noise.
  always @(negedge iClk) begin
    if (cyc == rd_due) iRdData = bmem.exists(rd_addr) ? bmem[rd_addr] : 32'h0;
    else               iRdData = $urandom;
    if (oCE && oWE) bmem[oAddr] = merge(bmem.exists(oAddr) ? bmem[oAddr] : 32'h0, oWrData, oByteEn);
    if (oCE && !oWE) begin
      rd_due  = cyc + LAT;
      rd_addr = oAddr;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input int bdly);
    int  c0, k;
    bit  seen;
    c0 = ce_cnt;
    iAWAddr = a; iWData = d; iWStrb = s; iAWValid = 1'b1; iWValid = (lead == 0);
    for (int i = 0; i < lead; i++) begin
      @(negedge iClk);
      check("aw_only_noaccept", {oAWReady, oWReady, oCE}, 0);
    end
    iWValid = 1'b1;
    seen = 0; k = 0;
    while (!seen && k < 20) begin
      @(negedge iClk); k++; seen = oAWReady;
    end
    check("wr_accept_lat", k, 1);
    if (!seen) begin iAWValid = 1'b0; iWValid = 1'b0; return; end
    check("wr_wready", oWReady, 1);
    check("wr_arready_quiet", oARReady, 0);
    mmem[a & EMASK] = merge(mm_rd(a), d, s);
    @(negedge iClk);
    iAWValid = 1'b0; iWValid = 1'b0; iAWAddr = $urandom; iWData = $urandom; iWStrb = 4'($urandom);
    check("wr_strobe", {oCE, oWE}, 2'b11);
    check("wr_addr", oAddr, a & EMASK);
    check("wr_data", oWrData, d);
    check("wr_byteen", oByteEn, s);
    check("wr_bvalid_early", oBValid, 0);
    @(negedge iClk);
    check("wr_bvalid", oBValid, 1);
    check("wr_bresp", oBResp, 0);
    for (int i = 0; i < bdly; i++) begin
      @(negedge iClk);
      check("wr_bvalid_hold", oBValid, 1);
    end
    iBReady = 1'b1;
    @(negedge iClk);
    iBReady = 1'b0;
    check("wr_bvalid_clr", oBValid, 0);
    check("wr_ce_count", ce_cnt - c0, 1);
  endtask

  task automatic do_read(input logic [31:0] a, input int rdly);
    int          c0, k;
    bit          seen;
    logic [31:0] exp;
    c0  = ce_cnt;
    exp = mm_rd(a);
    iARAddr = a; iARValid = 1'b1;
    seen = 0; k = 0;
    while (!seen && k < 20) begin
      @(negedge iClk); k++; seen = oARReady;
    end
    check("rd_accept_lat", k, 1);
    if (!seen) begin iARValid = 1'b0; return; end
    check("rd_awready_quiet", oAWReady, 0);
    @(negedge iClk);
    iARValid = 1'b0; iARAddr = $urandom;
    check("rd_strobe", {oCE, oWE}, 2'b10);
    check("rd_addr", oAddr, a & EMASK);
    check("rd_byteen", oByteEn, 4'hF);
    seen = 0; k = 1;
    while (!seen && k < 40) begin
      @(negedge iClk); k++; seen = oRValid;
    end
    check("rd_rvalid_lat", k, LAT + 2);
    check("rd_data", oRData, exp);
    check("rd_rresp", oRResp, 0);
    for (int i = 0; i < rdly; i++) begin
      @(negedge iClk);
      check("rd_rvalid_hold", {oRValid, oRData}, {1'b1, exp});
    end
    iRReady = 1'b1;
    @(negedge iClk);
    iRReady = 1'b0;
    check("rd_rvalid_clr", oRValid, 0);
    check("rd_ce_count", ce_cnt - c0, 1);
  endtask

  // Write and read requests held valid together: arbitration must alternate.
  task automatic tie_test();
    int          c0, nacc, nr, nb;
    logic [31:0] d;
    c0 = ce_cnt; nacc = 0; nr = 0; nb = 0;
    d = $urandom;
    iAWAddr = 32'h0000_0100; iWData = d; iWStrb = 4'hF;
    iARAddr = 32'hABC0_0100;
    iAWValid = 1'b1; iWValid = 1'b1; iARValid = 1'b1;
    iBReady = 1'b1; iRReady = 1'b1;
    for (int c = 0; c < 200 && nacc < 4; c++) begin
      @(negedge iClk);
      if (oAWReady || oARReady) begin
        check("tie_order", {oAWReady, oARReady}, (nacc % 2 == 0) ? 2'b10 : 2'b01);
        if (oAWReady) mmem[32'h100] = d;
        nacc++;
      end
      if (oRValid) begin check("tie_rdata", oRData, d); nr++; end
      if (oBValid) nb++;
    end
    check("tie_accepts", nacc, 4);
    @(negedge iClk);
    iAWValid = 1'b0; iWValid = 1'b0; iARValid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (oRValid) begin check("tie_rdata", oRData, d); nr++; end
      if (oBValid) nb++;
      @(negedge iClk);
    end
    iBReady = 1'b0; iRReady = 1'b0;
    check("tie_rresp_count", nr, 2);
    check("tie_bresp_count", nb, 2);
    check("tie_ce_count", ce_cnt - c0, 4);
  endtask

  initial begin
    logic [31:0] pool [6];
    pool = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hF_FFFC, 32'hA_BC10};

    repeat (3) @(negedge iClk);
    iRst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk);
      check("rst_ctrl", {oAWReady, oWReady, oARReady, oBValid, oRValid, oCE, oWE}, 0);
    end
    check("rst_addr", oAddr, 0);
    check("rst_wrdata", oWrData, 0);
    check("rst_rdata", oRData, 0);
    check("rst_byteen", oByteEn, 0);
    check("rst_resp", {oBResp, oRResp}, 0);
    check("rst_ce_count", ce_cnt, 0);

    do_write(32'h000A_BC10, 32'hDEAD_BEEF, 4'hF, 0, 3);
    do_write(32'h0000_0004, 32'h1234_5678, 4'hF, 0, 0);
    do_read(32'hFFF0_0004, 1);
    tie_test();
    do_write(32'h0000_0008, 32'hCAFE_F00D, 4'hF, 10, 1);
    do_read(32'h0000_0008, 0);

    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      a = {12'($urandom), 20'(pool[$urandom_range(0, 5)])};
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 3));
    end

    // Reset while the read is waiting on backend data: no response may appear.
    iARAddr = 32'h0000_000C; iARValid = 1'b1;
    @(negedge iClk);
    check("rst_rd_accept", oARReady, 1);
    @(negedge iClk);
    iARValid = 1'b0;
    check("rst_rd_strobe", oCE, 1);
    @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    check("rst_mid_ce", oCE, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk);
      check("rst_mid_no_resp", {oRValid, oBValid, oCE}, 0);
    end
    do_read(32'h0000_000C, 2);
    do_write(32'h5550_000C, 32'h0BAD_F00D, 4'b0101, 0, 0);
    do_read(32'h0000_000C, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
